// File: rtl/cpu_pkg.sv
// Shared types, instruction field positions and helpers for the 16-bit multi-cycle CPU.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_ADDI = 4'h5,
        OP_LD   = 4'h6,
        OP_ST   = 4'h7,
        OP_BEQ  = 4'h8,
        OP_JMP  = 4'h9,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } ctrl_state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3
    } alu_op_e;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int RS_HI  = 7;
    localparam int RS_LO  = 4;
    localparam int IMM_HI = 3;
    localparam int IMM_LO = 0;

    function automatic logic [15:0] sext4to16(input logic [3:0] v);
        return {{12{v[3]}}, v};
    endfunction

endpackage

// File: rtl/cpu_decode.sv
// Opcode decoder: maps the instruction opcode to datapath selects and instruction-class flags.
module cpu_decode
    import cpu_pkg::*;
(
    input  logic [3:0] op,
    output logic [2:0] alu_op,
    output logic       alu_src_sel,
    output logic       rb_sel,
    output logic       writes_reg,
    output logic       is_mem,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_jump,
    output logic       is_halt,
    output logic       is_illegal
);

    always_comb begin
        alu_op      = ALU_ADD;
        alu_src_sel = 1'b0;
        rb_sel      = 1'b0;
        writes_reg  = 1'b0;
        is_mem      = 1'b0;
        is_store    = 1'b0;
        is_branch   = 1'b0;
        is_jump     = 1'b0;
        is_halt     = 1'b0;
        is_illegal  = 1'b0;
        case (op)
            OP_NOP: ;
            OP_ADD: writes_reg = 1'b1;
            OP_SUB: begin
                alu_op     = ALU_SUB;
                writes_reg = 1'b1;
            end
            OP_AND: begin
                alu_op     = ALU_AND;
                writes_reg = 1'b1;
            end
            OP_OR: begin
                alu_op     = ALU_OR;
                writes_reg = 1'b1;
            end
            OP_ADDI: begin
                alu_src_sel = 1'b1;
                writes_reg  = 1'b1;
            end
            OP_LD: begin
                alu_src_sel = 1'b1;
                is_mem      = 1'b1;
                writes_reg  = 1'b1;
            end
            // Store data comes from rd, so read port B is steered to ir[11:8].
            OP_ST: begin
                alu_src_sel = 1'b1;
                rb_sel      = 1'b1;
                is_mem      = 1'b1;
                is_store    = 1'b1;
            end
            // BEQ compares rs with rd by subtracting and testing alu_zero.
            OP_BEQ: begin
                alu_op    = ALU_SUB;
                rb_sel    = 1'b1;
                is_branch = 1'b1;
            end
            OP_JMP:  is_jump = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control unit: fetch/decode/exec/mem/wb sequencing, PC/IR ownership,
// memory handshake and register-file write strobe.
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter bit          ILLEGAL_HALT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata,
    input  logic [15:0] alu_result,
    input  logic        alu_zero,
    output logic [15:0] pc,
    output logic [15:0] ir,
    output logic [2:0]  alu_op,
    output logic        alu_src_sel,
    output logic        rb_sel,
    output logic        reg_we,
    output logic [15:0] wb_data,
    output logic        halted,
    output logic        illegal
);

    ctrl_state_e state, state_d;

    logic [15:0] pc_q, ir_q, addr_q, mdr_q, alu_q;
    logic        illegal_q;
    logic        sel_valid;

    logic [2:0] dec_alu_op;
    logic       dec_src, dec_rb, dec_wr, dec_mem, dec_st;
    logic       dec_br, dec_jmp, dec_halt, dec_ill;
    logic [3:0] imm4;

    assign imm4 = ir_q[IMM_HI:IMM_LO];

    cpu_decode u_decode (
        .op          (ir_q[OP_HI:OP_LO]),
        .alu_op      (dec_alu_op),
        .alu_src_sel (dec_src),
        .rb_sel      (dec_rb),
        .writes_reg  (dec_wr),
        .is_mem      (dec_mem),
        .is_store    (dec_st),
        .is_branch   (dec_br),
        .is_jump     (dec_jmp),
        .is_halt     (dec_halt),
        .is_illegal  (dec_ill)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_INIT;
        else        state <= state_d;
    end

    // Memory-side outputs depend on state and registers only; mem_ready steers state_d alone.
    always_comb begin
        state_d   = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 16'h0000;
        reg_we    = 1'b0;
        halted    = 1'b0;
        sel_valid = 1'b0;
        case (state)
            S_INIT: state_d = S_FETCH;
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                sel_valid = 1'b1;
                if (dec_halt)                        state_d = S_HALT;
                else if (dec_ill)                    state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
                else if (dec_wr || dec_mem || dec_br) state_d = S_EXEC;
                else                                 state_d = S_FETCH;
            end
            S_EXEC: begin
                sel_valid = 1'b1;
                if (dec_mem)     state_d = S_MEM;
                else if (dec_wr) state_d = S_WB;
                else             state_d = S_FETCH;
            end
            S_MEM: begin
                sel_valid = 1'b1;
                mem_req   = 1'b1;
                mem_we    = dec_st;
                mem_addr  = addr_q;
                if (mem_ready) state_d = dec_st ? S_FETCH : S_WB;
            end
            S_WB: begin
                sel_valid = 1'b1;
                reg_we    = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT:  halted  = 1'b1;
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            ir_q      <= 16'h0000;
            addr_q    <= 16'h0000;
            mdr_q     <= 16'h0000;
            alu_q     <= 16'h0000;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir_q <= mem_rdata;
                        pc_q <= pc_q + 16'd1;
                    end
                end
                S_DECODE: begin
                    if (dec_jmp) pc_q <= {pc_q[15:12], ir_q[11:0]};
                    if (dec_ill) illegal_q <= 1'b1;
                end
                // Branch offset is relative to the pc already advanced past the BEQ.
                S_EXEC: begin
                    alu_q  <= alu_result;
                    addr_q <= alu_result;
                    if (dec_br && alu_zero) pc_q <= pc_q + sext4to16(imm4);
                end
                S_MEM: begin
                    if (mem_ready && !dec_st) mdr_q <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    assign pc          = pc_q;
    assign ir          = ir_q;
    assign illegal     = illegal_q;
    assign wb_data     = (dec_mem && !dec_st) ? mdr_q : alu_q;
    assign alu_op      = sel_valid ? dec_alu_op : ALU_ADD;
    assign alu_src_sel = sel_valid & dec_src;
    assign rb_sel      = sel_valid & dec_rb;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: instruction-by-instruction stimulus with hand-computed expectations.
module tb_cpu_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic [15:0] alu_result;
    logic        alu_zero;
    logic        mem_req, mem_we, alu_src_sel, rb_sel, reg_we, halted, illegal;
    logic [15:0] mem_addr, pc, ir, wb_data;
    logic [2:0]  alu_op;

    int n_asserts = 0;
    int n_fail    = 0;

    cpu_ctrl_fsm #(
        .RESET_PC     (16'h0000),
        .ILLEGAL_HALT (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .pc          (pc),
        .ir          (ir),
        .alu_op      (alu_op),
        .alu_src_sel (alu_src_sel),
        .rb_sel      (rb_sel),
        .reg_we      (reg_we),
        .wb_data     (wb_data),
        .halted      (halted),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Completes a zero-wait fetch of instr; leaves the DUT in DECODE.
    task automatic fetch(input logic [15:0] instr);
        mem_ready = 1'b1;
        mem_rdata = instr;
        tick();
        mem_rdata = 16'h0000;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b0; mem_rdata = 16'h0000; alu_result = 16'h0000; alu_zero = 1'b0;
        tick(); tick();
        n_asserts++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
        n_asserts++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0000", mem_addr); end
        n_asserts++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL rst_pc: got %h want 0000", pc); end
        n_asserts++; if (ir !== 16'h0000) begin n_fail++; $display("FAIL rst_ir: got %h want 0000", ir); end
        n_asserts++; if ({reg_we, halted, illegal} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b want 000", {reg_we, halted, illegal}); end
        rst_n = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h1123;
        #1;
        n_asserts++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL init_no_req: got %b want 0", mem_req); end
        tick();
        n_asserts++; if ({mem_req, mem_we} !== 2'b10) begin n_fail++; $display("FAIL fetch0_req_we: got %b want 10", {mem_req, mem_we}); end
        n_asserts++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL fetch0_addr: got %h want 0000", mem_addr); end
    endtask

    task automatic test_alu();
        fetch(16'h1123);
        n_asserts++; if (ir !== 16'h1123) begin n_fail++; $display("FAIL alu_ir: got %h want 1123", ir); end
        n_asserts++; if (pc !== 16'h0001) begin n_fail++; $display("FAIL alu_pc: got %h want 0001", pc); end
        n_asserts++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL alu_decode_req: got %b want 0", mem_req); end
        alu_result = 16'h0055;
        tick();
        n_asserts++; if ({alu_op, alu_src_sel} !== 4'b0000) begin n_fail++; $display("FAIL alu_exec_sel: got %b want 0000", {alu_op, alu_src_sel}); end
        n_asserts++; if (reg_we !== 1'b0) begin n_fail++; $display("FAIL alu_exec_we: got %b want 0", reg_we); end
        tick();
        n_asserts++; if (reg_we !== 1'b1) begin n_fail++; $display("FAIL alu_wb_we: got %b want 1", reg_we); end
        n_asserts++; if (wb_data !== 16'h0055) begin n_fail++; $display("FAIL alu_wb_data: got %h want 0055", wb_data); end
        tick();
        n_asserts++; if (reg_we !== 1'b0) begin n_fail++; $display("FAIL alu_we_drop: got %b want 0", reg_we); end
        n_asserts++; if (mem_addr !== 16'h0001) begin n_fail++; $display("FAIL alu_next_fetch: got %h want 0001", mem_addr); end
    endtask

    task automatic test_addi();
        fetch(16'h512F);
        n_asserts++; if (alu_src_sel !== 1'b1) begin n_fail++; $display("FAIL addi_src_sel: got %b want 1", alu_src_sel); end
        alu_result = 16'h0041;
        tick(); tick();
        n_asserts++; if (reg_we !== 1'b1) begin n_fail++; $display("FAIL addi_we: got %b want 1", reg_we); end
        n_asserts++; if (wb_data !== 16'h0041) begin n_fail++; $display("FAIL addi_wb_data: got %h want 0041", wb_data); end
        tick();
        n_asserts++; if (reg_we !== 1'b0) begin n_fail++; $display("FAIL addi_we_one_cycle: got %b want 0", reg_we); end
        n_asserts++; if (mem_addr !== 16'h0002) begin n_fail++; $display("FAIL addi_next_fetch: got %h want 0002", mem_addr); end
    endtask

    task automatic test_ld();
        fetch(16'h6234);
        alu_result = 16'h0100;
        tick();
        n_asserts++; if ({alu_op, alu_src_sel} !== 4'b0001) begin n_fail++; $display("FAIL ld_exec_sel: got %b want 0001", {alu_op, alu_src_sel}); end
        mem_ready = 1'b0; mem_rdata = 16'hDEAD;
        tick();
        alu_result = 16'h1234;
        for (int i = 0; i < 4; i++) begin
            n_asserts++; if ({mem_req, mem_we} !== 2'b10) begin n_fail++; $display("FAIL ld_mem_req_we[%0d]: got %b want 10", i, {mem_req, mem_we}); end
            n_asserts++; if (mem_addr !== 16'h0100) begin n_fail++; $display("FAIL ld_mem_addr[%0d]: got %h want 0100", i, mem_addr); end
            if (i == 3) begin mem_ready = 1'b1; mem_rdata = 16'hBEEF; end
            tick();
        end
        mem_rdata = 16'h0000;
        n_asserts++; if (reg_we !== 1'b1) begin n_fail++; $display("FAIL ld_wb_we: got %b want 1", reg_we); end
        n_asserts++; if (wb_data !== 16'hBEEF) begin n_fail++; $display("FAIL ld_wb_data: got %h want BEEF", wb_data); end
        n_asserts++; if ({mem_req, mem_addr} !== 17'h0) begin n_fail++; $display("FAIL ld_wb_idle_bus: got %h want 0", {mem_req, mem_addr}); end
        tick();
        n_asserts++; if (mem_addr !== 16'h0003) begin n_fail++; $display("FAIL ld_next_fetch: got %h want 0003", mem_addr); end
    endtask

    task automatic test_st();
        fetch(16'h7234);
        n_asserts++; if ({rb_sel, alu_src_sel} !== 2'b11) begin n_fail++; $display("FAIL st_sels: got %b want 11", {rb_sel, alu_src_sel}); end
        alu_result = 16'h0200;
        tick(); tick();
        n_asserts++; if ({mem_req, mem_we, reg_we} !== 3'b110) begin n_fail++; $display("FAIL st_mem_strobes: got %b want 110", {mem_req, mem_we, reg_we}); end
        n_asserts++; if (mem_addr !== 16'h0200) begin n_fail++; $display("FAIL st_mem_addr: got %h want 0200", mem_addr); end
        tick();
        n_asserts++; if ({mem_we, reg_we} !== 2'b00) begin n_fail++; $display("FAIL st_after: got %b want 00", {mem_we, reg_we}); end
        n_asserts++; if (mem_addr !== 16'h0004) begin n_fail++; $display("FAIL st_next_fetch: got %h want 0004", mem_addr); end
    endtask

    task automatic test_beq();
        fetch(16'h9010);
        tick();
        n_asserts++; if (mem_addr !== 16'h0010) begin n_fail++; $display("FAIL beq_setup_addr: got %h want 0010", mem_addr); end
        fetch(16'h801F);
        n_asserts++; if (pc !== 16'h0011) begin n_fail++; $display("FAIL beq_pc_inc: got %h want 0011", pc); end
        n_asserts++; if ({rb_sel, alu_op} !== 4'b1001) begin n_fail++; $display("FAIL beq_sels: got %b want 1001", {rb_sel, alu_op}); end
        alu_zero = 1'b1;
        tick(); tick();
        n_asserts++; if (pc !== 16'h0010) begin n_fail++; $display("FAIL beq_taken_pc: got %h want 0010", pc); end
        n_asserts++; if ({mem_req, mem_addr} !== {1'b1, 16'h0010}) begin n_fail++; $display("FAIL beq_taken_fetch: got %h want 10010", {mem_req, mem_addr}); end
        fetch(16'h801F);
        alu_zero = 1'b0;
        tick(); tick();
        n_asserts++; if (pc !== 16'h0011) begin n_fail++; $display("FAIL beq_not_taken_pc: got %h want 0011", pc); end
    endtask

    task automatic test_jmp();
        fetch(16'h9FFF);
        tick();
        n_asserts++; if (pc !== 16'h0FFF) begin n_fail++; $display("FAIL jmp_0fff: got %h want 0FFF", pc); end
        fetch(16'h0000);
        n_asserts++; if (pc !== 16'h1000) begin n_fail++; $display("FAIL nop_pc_carry: got %h want 1000", pc); end
        tick();
        n_asserts++; if ({mem_req, mem_addr} !== {1'b1, 16'h1000}) begin n_fail++; $display("FAIL nop_latency: got %h want 11000", {mem_req, mem_addr}); end
        fetch(16'h9234);
        tick();
        n_asserts++; if (pc !== 16'h1234) begin n_fail++; $display("FAIL jmp_1234: got %h want 1234", pc); end
        fetch(16'h9ABC);
        tick();
        n_asserts++; if (pc !== 16'h1ABC) begin n_fail++; $display("FAIL jmp_target: got %h want 1ABC", pc); end
        n_asserts++; if (mem_addr !== 16'h1ABC) begin n_fail++; $display("FAIL jmp_fetch_addr: got %h want 1ABC", mem_addr); end
    endtask

    task automatic test_reset_mid_mem();
        fetch(16'h6000);
        alu_result = 16'h0300;
        tick();
        mem_ready = 1'b0;
        tick();
        n_asserts++; if ({mem_req, mem_addr} !== {1'b1, 16'h0300}) begin n_fail++; $display("FAIL mid_mem_req: got %h want 10300", {mem_req, mem_addr}); end
        rst_n = 1'b0;
        tick();
        n_asserts++; if ({mem_req, mem_addr} !== 17'h0) begin n_fail++; $display("FAIL mid_rst_req: got %h want 0", {mem_req, mem_addr}); end
        n_asserts++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_pc: got %h want 0000", pc); end
        n_asserts++; if (ir !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_ir: got %h want 0000", ir); end
        rst_n = 1'b1; mem_ready = 1'b1;
        tick();
        n_asserts++; if ({mem_req, mem_addr} !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL mid_rst_refetch: got %h want 10000", {mem_req, mem_addr}); end
    endtask

    task automatic test_illegal();
        fetch(16'hB000);
        n_asserts++; if ({illegal, halted} !== 2'b00) begin n_fail++; $display("FAIL ill_decode_flags: got %b want 00", {illegal, halted}); end
        tick();
        n_asserts++; if ({illegal, halted, mem_req} !== 3'b110) begin n_fail++; $display("FAIL ill_halt_flags: got %b want 110", {illegal, halted, mem_req}); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_asserts++; if ({halted, mem_req, reg_we} !== 3'b100) begin n_fail++; $display("FAIL halt_absorb[%0d]: got %b want 100", i, {halted, mem_req, reg_we}); end
        end
        rst_n = 1'b0;
        tick();
        n_asserts++; if ({illegal, halted} !== 2'b00) begin n_fail++; $display("FAIL halt_rst_clear: got %b want 00", {illegal, halted}); end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_addi();
        test_ld();
        test_st();
        test_beq();
        test_jmp();
        test_reset_mid_mem();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
